// File: rtl/barrel_shifter_csd_sched.sv
// barrel_shifter_csd_sched: schedules shift jobs from two requesters onto one
// external barrel_shifter_csd. Requesters take turns through a round-robin pointer.
// Amounts above W-1 are split into two shifter passes. Each job returns one
// tagged result on a valid/ready response port.
// Optional build macro: BKM_SHIFT_SCHED_BYPASS_EN. When it is defined, an
// amount-0 job goes straight to RESP without using the shifter.
module barrel_shifter_csd_sched #(
  parameter int W     = 8,
  parameter int LOG2W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [1:0]               req_dir,
  input  logic [1:0]               req_op,
  input  logic [1:0]               req_shift_t,
  input  logic [2*(LOG2W+1)-1:0]   req_amt,
  input  logic [2*W-1:0]           req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [W-1:0]             rsp_data,
  output logic                     bs_dir,
  output logic                     bs_op,
  output logic                     bs_shift_t,
  output logic [LOG2W-1:0]         bs_sel,
  output logic [W-1:0]             bs_in,
  input  logic [W-1:0]             bs_out,
  output logic                     busy
);

  localparam int AW = LOG2W + 1;
  // Largest total amount two passes can cover; 2W-1 is clamped down to this.
  localparam logic [AW-1:0]    AMT_MAX  = AW'(2 * W - 2);
  localparam logic [AW-1:0]    PASS_MAX = AW'(W - 1);
  localparam logic [LOG2W-1:0] SEL_MAX  = LOG2W'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_next;

  logic           ptr;
  logic           job_dir, job_op, job_shift_t, job_id;
  logic [AW-1:0]  job_amt;     // remaining amount; reduced after each pass
  logic [W-1:0]   job_data;

  logic           grant_idx;
  logic           accept;
  logic [AW-1:0]  amt_raw, amt_in;
  logic [W-1:0]   data_in;
  logic [LOG2W-1:0] sel;
  logic [AW-1:0]  rem;

  // Grant: one-hot ready to the highest-priority valid requester, and only in IDLE
  always_comb begin
    grant_idx = 1'b0;
    req_ready = 2'b00;
    if (state == IDLE) begin
      case (req_valid)
        2'b01:   begin grant_idx = 1'b0; req_ready = 2'b01; end
        2'b10:   begin grant_idx = 1'b1; req_ready = 2'b10; end
        2'b11:   begin grant_idx = ptr;  req_ready = ptr ? 2'b10 : 2'b01; end
        default: begin grant_idx = 1'b0; req_ready = 2'b00; end
      endcase
    end else begin
      grant_idx = 1'b0;
      req_ready = 2'b00;
    end
  end

  assign accept = |req_ready;

  // Select the granted requester's payload and clamp its amount to the two-pass limit
  always_comb begin
    if (grant_idx) begin
      amt_raw = req_amt[2*AW-1:AW];
      data_in = req_data[2*W-1:W];
    end else begin
      amt_raw = req_amt[AW-1:0];
      data_in = req_data[W-1:0];
    end
    if (amt_raw > AMT_MAX) amt_in = AMT_MAX;
    else                   amt_in = amt_raw;
  end

  // Per-pass shifter select and the amount still left after this pass
  always_comb begin
    sel = {LOG2W{1'b0}};
    case (state)
      PASS1: begin
        if (job_amt >= PASS_MAX) sel = SEL_MAX;
        else                     sel = job_amt[LOG2W-1:0];
      end
      PASS2:   sel = job_amt[LOG2W-1:0];
      default: sel = {LOG2W{1'b0}};
    endcase
    rem = job_amt - {1'b0, sel};
  end

  // Next-state logic for the job sequencer
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef BKM_SHIFT_SCHED_BYPASS_EN
          if (amt_in == {AW{1'b0}}) state_next = RESP;
          else                      state_next = PASS1;
`else
          state_next = PASS1;
`endif
        end else begin
          state_next = IDLE;
        end
      end
      PASS1: begin
        if (rem != {AW{1'b0}}) state_next = PASS2;
        else                   state_next = RESP;
      end
      PASS2:   state_next = RESP;
      RESP: begin
        if (rsp_ready) state_next = IDLE;
        else           state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Job registers: capture on accept, take shifter output on each pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= 1'b0;
      job_dir     <= 1'b0;
      job_op      <= 1'b0;
      job_shift_t <= 1'b0;
      job_id      <= 1'b0;
      job_amt     <= {AW{1'b0}};
      job_data    <= {W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ptr         <= ~grant_idx;
            job_dir     <= req_dir[grant_idx];
            job_op      <= req_op[grant_idx];
            job_shift_t <= req_shift_t[grant_idx];
            job_id      <= grant_idx;
            job_amt     <= amt_in;
            job_data    <= data_in;
          end
        end
        PASS1, PASS2: begin
          job_data <= bs_out;
          job_amt  <= rem;
        end
        default: begin
        end
      endcase
    end
  end

  assign bs_dir     = job_dir;
  assign bs_op      = job_op;
  assign bs_shift_t = job_shift_t;
  assign bs_sel     = sel;
  assign bs_in      = job_data;
  assign rsp_valid  = (state == RESP);
  assign rsp_data   = job_data;
  assign rsp_id     = job_id;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_barrel_shifter_csd_sched.sv
// Testbench for barrel_shifter_csd_sched. It includes a behavioural model of the
// external shifter: dir=1 shifts right, shift_t=1 is arithmetic, and op does not
// change the data path. Expected results come from applying the clamped total
// amount in one shift. Latency expectations follow BKM_SHIFT_SCHED_BYPASS_EN.
module tb_barrel_shifter_csd_sched;
  localparam int W = 8;
  localparam int LOG2W = 3;
  localparam int AW = LOG2W + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, req_dir, req_op, req_shift_t;
  logic [2*AW-1:0]  req_amt;
  logic [2*W-1:0]   req_data;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0]     rsp_data;
  logic             bs_dir, bs_op, bs_shift_t, busy;
  logic [LOG2W-1:0] bs_sel;
  logic [W-1:0]     bs_in, bs_out;

  int checks = 0;
  int errors = 0;
  logic ptr_m;  // model of the round-robin pointer

  barrel_shifter_csd_sched #(.W(W), .LOG2W(LOG2W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dir(req_dir), .req_op(req_op), .req_shift_t(req_shift_t),
    .req_amt(req_amt), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .bs_dir(bs_dir), .bs_op(bs_op), .bs_shift_t(bs_shift_t),
    .bs_sel(bs_sel), .bs_in(bs_in), .bs_out(bs_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] shift_f(input logic [W-1:0] d, input logic dir,
                                           input logic st, input int n);
    logic signed [W-1:0] s;
    s = d;
    if (dir) begin
      if (st) return s >>> n;
      else    return d >> n;
    end else begin
      return d << n;
    end
  endfunction

  // Combinational model of the external barrel shifter
  always_comb bs_out = shift_f(bs_in, bs_dir, bs_shift_t, int'(bs_sel));

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b00; req_dir = 2'b00; req_op = 2'b00;
    req_shift_t = 2'b00; req_amt = '0; req_data = '0; rsp_ready = 1'b0;
    ptr_m = 1'b0;
    #12;
    checks++;
    if ({rsp_valid, busy, rsp_id, rsp_data, bs_sel, bs_in, req_ready} !== '0)
      begin errors++; $display("FAIL reset_outputs: rsp_valid=%b busy=%b rsp_id=%b rsp_data=%h bs_sel=%0d bs_in=%h req_ready=%b, all required 0",
                               rsp_valid, busy, rsp_id, rsp_data, bs_sel, bs_in, req_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [W-1:0] d0, d1, e;
    int r, lat;
    d0 = W'($urandom); d1 = W'($urandom);
    req_dir = 2'b11; req_shift_t = 2'b01; req_op = 2'b10;
    req_amt = {AW'(1), AW'(1)}; req_data = {d1, d0};
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      r = int'(ptr_m);
      #1;
      checks++;
      if (req_ready !== (r == 0 ? 2'b01 : 2'b10))
        begin errors++; $display("FAIL contention_grant[%0d]: req_ready=%b required %b", k, req_ready, (r == 0 ? 2'b01 : 2'b10)); end
      @(posedge clk); ptr_m = (r == 0);
      lat = 1;
      @(negedge clk);
      while (rsp_valid !== 1'b1 && lat < 8) begin @(posedge clk); lat++; @(negedge clk); end
      e = shift_f(r == 0 ? d0 : d1, 1'b1, r == 0, 1);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== r[0] || rsp_data !== e)
        begin errors++; $display("FAIL contention_rsp[%0d]: valid=%b id=%b data=%h required 1 %0d %h", k, rsp_valid, rsp_id, rsp_data, r, e); end
      @(posedge clk); @(negedge clk);
    end
    req_valid = 2'b00; rsp_ready = 1'b0;
  endtask

  task automatic test_shift(input int r, input logic dir, input logic st, input logic op,
                            input int amt, input logic [W-1:0] data, input int stall);
    int amtc, p1, p2, exp_lat, lat, pass;
    logic [W-1:0] e, hold_data;
    logic [1:0] exp_rdy;
    logic [LOG2W-1:0] es;
    amtc = (amt > 2*W-2) ? 2*W-2 : amt;
    p1 = (amtc > W-1) ? W-1 : amtc;
    p2 = amtc - p1;
    exp_lat = (amtc >= W) ? 3 : 2;
`ifdef BKM_SHIFT_SCHED_BYPASS_EN
    if (amtc == 0) exp_lat = 1;
`endif
    e = shift_f(data, dir, st, amtc);
    exp_rdy = (r == 0) ? 2'b01 : 2'b10;
    req_dir[r] = dir; req_op[r] = op; req_shift_t[r] = st;
    req_amt[r*AW +: AW] = AW'(amt); req_data[r*W +: W] = data;
    req_valid = exp_rdy; rsp_ready = (stall == 0);
    #1;
    checks++;
    if (req_ready !== exp_rdy)
      begin errors++; $display("FAIL single_grant: req_ready=%b required %b", req_ready, exp_rdy); end
    @(posedge clk); ptr_m = (r == 0);
    lat = 1;
    @(negedge clk); req_valid = 2'b00;
    pass = 0;
    while (rsp_valid !== 1'b1 && lat < 8) begin
      es = LOG2W'(pass == 0 ? p1 : p2);
      checks++;
      if (bs_sel !== es || busy !== 1'b1 || req_ready !== 2'b00)
        begin errors++; $display("FAIL pass%0d: bs_sel=%0d busy=%b req_ready=%b required %0d 1 00", pass + 1, bs_sel, busy, req_ready, es); end
      if (pass == 0) begin
        checks++;
        if ({bs_dir, bs_op, bs_shift_t, bs_in} !== {dir, op, st, data})
          begin errors++; $display("FAIL forward: dir/op/st/in=%b%b%b %h required %b%b%b %h", bs_dir, bs_op, bs_shift_t, bs_in, dir, op, st, data); end
      end
      pass++;
      @(posedge clk); lat++; @(negedge clk);
    end
    checks++;
    if (lat !== exp_lat)
      begin errors++; $display("FAIL latency: amt=%0d cycles=%0d required %0d", amt, lat, exp_lat); end
    checks++;
    if (rsp_data !== e || rsp_id !== r[0])
      begin errors++; $display("FAIL result: amt=%0d data=%h id=%b required %h %0d", amt, rsp_data, rsp_id, e, r); end
    hold_data = rsp_data;
    for (int i = 0; i < stall; i++) begin
      req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b00)
        begin errors++; $display("FAIL stall_ready: req_ready=%b required 00", req_ready); end
      @(posedge clk); @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== hold_data || rsp_id !== r[0] || busy !== 1'b1)
        begin errors++; $display("FAIL stall_hold: valid=%b data=%h id=%b busy=%b required 1 %h %0d 1", rsp_valid, rsp_data, rsp_id, busy, hold_data, r); end
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL handshake: rsp_valid=%b busy=%b required 0 0", rsp_valid, busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit seen;
    req_dir[0] = 1'b1; req_shift_t[0] = 1'b1; req_op[0] = 1'b0;
    req_amt[AW-1:0] = AW'(9); req_data[W-1:0] = 8'h80;
    req_valid = 2'b01; rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk); req_valid = 2'b00;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bs_sel !== 3'd2)
      begin errors++; $display("FAIL abort_pass2: bs_sel=%0d required 2", bs_sel); end
    rst_n = 1'b0; ptr_m = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, busy, bs_sel, rsp_data, rsp_id, bs_in} !== '0)
      begin errors++; $display("FAIL abort_reset: valid=%b busy=%b sel=%0d data=%h id=%b in=%h required all 0", rsp_valid, busy, bs_sel, rsp_data, rsp_id, bs_in); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen)
      begin errors++; $display("FAIL abort_no_rsp: activity after reset release=%b required 0", seen); end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01)
      begin errors++; $display("FAIL abort_pointer: req_ready=%b required 01", req_ready); end
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_shift(0, 1'b1, 1'b1, 1'b0, 3, 8'h80, 0);
    test_shift(1, 1'b1, 1'b1, 1'b1, 9, 8'h80, 0);
    test_shift(0, 1'b0, 1'b0, 1'b0, 15, 8'h40, 0);
    test_shift(1, 1'b0, 1'b0, 1'b0, 7, 8'h81, 5);
    test_shift(0, 1'b1, 1'b0, 1'b1, 8, 8'hF0, 0);
    test_shift(1, 1'b1, 1'b1, 1'b0, 0, 8'h5A, 0);
    test_shift(0, 1'b1, 1'b0, 1'b0, 14, 8'hFF, 2);
    for (int n = 0; n < 24; n++)
      test_shift(int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 15)), W'($urandom), int'($urandom_range(0, 3)));
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/barrel_shifter_csd_sched.md
Name: barrel_shifter_csd_sched

Overview:
Two-requester scheduler for the shared barrel_shifter_csd datapath in the BKM FPU. Both iteration datapaths issue shift jobs through it.
- Arbitrates round-robin between requesters.
- Decomposes shift amounts wider than one shifter pass into two sequential passes.
- Returns one tagged result per job through a valid/ready response port.
- Drives an external barrel_shifter_csd instance through its bs_* ports and captures its output.

Parameters:
W, 8, datapath width; equals the shifter W
LOG2W, 3, shifter select width; W = 2**LOG2W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  2  job request valid; bit i is requester i
req_ready  out  2  job accepted when req_valid[i] & req_ready[i]
req_dir  in  2  per-requester shift direction; forwarded to bs_dir
req_op  in  2  per-requester op; forwarded unmodified to bs_op
req_shift_t  in  2  per-requester shift type; forwarded to bs_shift_t
req_amt  in  2*(LOG2W+1)  per-requester shift amount; slice i = bits [(i+1)*(LOG2W+1)-1 : i*(LOG2W+1)]
req_data  in  2*W  per-requester operand; slice i = bits [(i+1)*W-1 : i*W]
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumed when rsp_valid & rsp_ready
rsp_id  out  1  index of the requester owning the result
rsp_data  out  W  shifted result
bs_dir  out  1  to shifter dir
bs_op  out  1  to shifter op
bs_shift_t  out  1  to shifter shift_t
bs_sel  out  LOG2W  to shifter sel
bs_in  out  W  to shifter in
bs_out  in  W  from shifter out (combinational)
busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: single clock clk; rst_n asynchronous, active-low.
- Reset values:
  - State IDLE; round-robin pointer = 0 (requester 0 has priority).
  - All job registers (dir, op, shift_t, amt, data, id) = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0, bs_sel = 0, bs_in = 0.
- FSM states: IDLE, PASS1, PASS2, RESP.
- IDLE, request grant:
  - req_ready is combinational and is nonzero only in IDLE.
  - Exactly one bit of req_ready is set: the highest-priority valid requester.
  - If only one requester is valid, it is granted.
  - If both are valid, the pointer picks; on grant the pointer moves to the other requester.
  - req_ready = 2'b00 when no request is valid.
- IDLE, on accept: capture dir, op, shift_t, data and id = granted index.
  - Capture amt clamped to 2W-2 (amt = 2W-1 is stored as 2W-2).
  - Next state is PASS1.
- PASS1:
  - bs_sel = W-1 if amt >= W-1, else amt.
  - data_reg <= bs_out; rem <= amt - bs_sel.
  - Next state is PASS2 if rem != 0, else RESP.
- PASS2: bs_sel = rem (range 1..W-1); data_reg <= bs_out; next state RESP.
- bs_in, bs_dir, bs_op, bs_shift_t are driven from the job registers in all states. bs_sel = 0 outside PASS1/PASS2.
- RESP:
  - rsp_valid = 1; rsp_data = data_reg; rsp_id = id.
  - rsp_valid, rsp_data and rsp_id stay stable until rsp_ready.
  - On handshake, next state is IDLE. No new accept occurs in the same cycle.
- Latency from the accept edge:
  - rsp_valid rises 2 cycles later when amt <= W-1.
  - rsp_valid rises 3 cycles later when amt >= W.
  - Throughput: at most one job in flight.
- Amount 0 takes one PASS1 with bs_sel = 0; the result passes through the shifter unchanged.
- Requests arriving while busy stall (req_ready = 0). Requesters must hold valid and payload until accepted.
- rst_n asserted mid-job: the job is dropped, with no response. All outputs go to their reset values immediately.

Optional Feature:
- Macro: BKM_SHIFT_SCHED_BYPASS_EN.
- When defined: a job with amt == 0 goes from IDLE directly to RESP with data_reg = req_data. rsp_valid rises 1 cycle after accept, and the shifter is not exercised (bs_sel stays 0).
- When undefined: amt == 0 takes the normal PASS1 path with 2-cycle latency.
- All other behaviour is identical with and without the macro.

Test Plan:
- Arithmetic right shift, one pass: req 0 only, dir=right, shift_t=arith, amt=3, data=8'h80 -> rsp_data=8'hF0, rsp_id=0, rsp_valid 2 cycles after accept, bs_sel=3 in PASS1.
- Two-pass shift: req 1 only, right arithmetic, amt=9, data=8'h80 -> bs_sel=7 then 2, rsp_data=8'hFF, rsp_id=1, latency 3.
- Simultaneous requests: both req_valid held from reset with amt=1 -> grants go 0,1,0,1; rsp_id alternates; no requester is granted twice in a row under contention.
- Response backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid/rsp_data/rsp_id stable, req_ready=2'b00, busy=1. The job completes on the cycle rsp_ready rises.
- Amount clamp: amt=15, left logical, data=8'h40 -> bs_sel=7 then 7, rsp_data=8'h00.
- Reset abort: rst_n low during PASS2 -> rsp_valid=0, busy=0, bs_sel=0 immediately, no response after release, pointer=0. With BKM_SHIFT_SCHED_BYPASS_EN: amt=0, data=8'h5A -> rsp_data=8'h5A, 1 cycle after accept.
